// File: rtl/mult_arbiter.sv
// mult_arbiter: NREQ requesters share one combinational 4x4 unsigned array
// multiplier, one transaction outstanding at a time.
// Build option: define MULT_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no pointer state); leave it undefined for round-robin arbitration.
module mult_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_prod,
    output logic [1:0]        rsp_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Array multiplier: sum of shifted partial products, one row per b bit.
    function automatic logic [7:0] mul4x4(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] acc;
        acc = 8'd0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + (b[i] ? ({4'd0, a} << i) : 8'd0);
        end
        return acc;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic [1:0] op_id_q, op_id_d;
    logic [7:0] prod_q, prod_d;
    logic [1:0] id_q, id_d;

    logic [1:0] arb_base_s;
    logic       hi_found_s, lo_found_s;
    logic [1:0] hi_idx_s, lo_idx_s;
    logic       grant_found_s;
    logic [1:0] grant_idx_s;
    logic       hs_s;
    logic [3:0] sel_a_s, sel_b_s;

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Search always starts at requester 0.
    assign arb_base_s = 2'd0;
`else
    logic [1:0] ptr_q, ptr_d;

    assign arb_base_s = ptr_q;

    // Pointer moves just past the winner on every handshake.
    always_comb begin
        ptr_d = ptr_q;
        if (hs_s) begin
            ptr_d = (grant_idx_s == 2'(NREQ - 1)) ? 2'd0 : grant_idx_s + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Two-pass search: lowest valid index at/above the base, else lowest overall.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = 2'd0;
        lo_idx_s   = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found_s = 1'b1;
                lo_idx_s   = 2'(i);
                if (2'(i) >= arb_base_s) begin
                    hi_found_s = 1'b1;
                    hi_idx_s   = 2'(i);
                end else begin
                    hi_found_s = hi_found_s;
                end
            end else begin
                lo_found_s = lo_found_s;
            end
        end
    end

    assign grant_found_s = hi_found_s | lo_found_s;
    assign grant_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    assign hs_s          = (state_q == IDLE) && grant_found_s;

    // Grant only the winner, only while idle; also select the winner's operands.
    always_comb begin
        req_ready = '0;
        sel_a_s   = 4'd0;
        sel_b_s   = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = hs_s && (grant_idx_s == 2'(i));
            if (grant_idx_s == 2'(i)) begin
                sel_a_s = req_a[4*i +: 4];
                sel_b_s = req_b[4*i +: 4];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // FSM next state plus operand capture and product/result registration.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_id_d = op_id_q;
        prod_d  = prod_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    state_d = BUSY;
                    op_a_d  = sel_a_s;
                    op_b_d  = sel_b_s;
                    op_id_d = grant_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                state_d = RESP;
                prod_d  = mul4x4(op_a_q, op_b_q);
                id_d    = op_id_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and response registers; reset discards any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= 4'd0;
            op_b_q  <= 4'd0;
            op_id_q <= 2'd0;
            prod_q  <= 8'd0;
            id_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            op_id_q <= op_id_d;
            prod_q  <= prod_d;
            id_q    <= id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_prod  = prod_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (NREQ=4).
module tb_mult_arbiter;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_prod;
    logic [1:0]        rsp_id;

    int errors = 0;
    int checks = 0;

    mult_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", rsp_valid); end
        checks++; if (rsp_prod !== 8'h00) begin errors++; $display("FAIL reset_prod got=%0h exp=0", rsp_prod); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0h exp=0", rsp_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%0h exp=0", req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // 7*9 through requester 0, granted in the first clock after reset release.
    task automatic test_single();
        req_valid = 4'b0001;
        req_a     = 16'h0007;
        req_b     = 16'h0009;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%0h exp=1", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_busy_valid got=%0h exp=0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_busy_ready got=%0h exp=0", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0h exp=1", rsp_valid); end
        checks++; if (rsp_prod !== 8'h3F) begin errors++; $display("FAIL single_prod got=%0h exp=3f", rsp_prod); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got=%0h exp=0", rsp_id); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drop got=%0h exp=0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    // All four requesting; operands a=i+1, b=i+2 identify the winner.
    task automatic test_round_robin();
        do_reset();
        req_a     = 16'h4321;
        req_b     = 16'h5432;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int         exp_w;
            logic [3:0] exp_rdy;
            logic [7:0] exp_p;
`ifdef MULT_ARB_FIXED_PRIO_EN
            exp_w = 0;
`else
            exp_w = k % 4;
`endif
            exp_rdy = 4'(1 << exp_w);
            exp_p   = 8'((exp_w + 1) * (exp_w + 2));
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d] got=%0h exp=%0h", k, req_ready, exp_rdy); end
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got=%0h exp=1", k, rsp_valid); end
            checks++; if (rsp_prod !== exp_p) begin errors++; $display("FAIL rr_prod[%0d] got=%0h exp=%0h", k, rsp_prod, exp_p); end
            checks++; if (rsp_id !== 2'(exp_w)) begin errors++; $display("FAIL rr_id[%0d] got=%0h exp=%0h", k, rsp_id, exp_w); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_accept_ready[%0d] got=%0h exp=0", k, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = 4'h0;
        rsp_ready = 1'b0;
    endtask

    // 15*15 through requester 2 with the consumer stalled for 5 cycles.
    task automatic test_backpressure();
        logic [3:0] exp_next;
        req_valid = 4'b0100;
        req_a     = 16'h0F00;
        req_b     = 16'h0F00;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got=%0h exp=4", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%0h exp=1", c, rsp_valid); end
            checks++; if (rsp_prod !== 8'hE1) begin errors++; $display("FAIL bp_prod[%0d] got=%0h exp=e1", c, rsp_prod); end
            checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL bp_id[%0d] got=%0h exp=2", c, rsp_id); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%0h exp=0", c, req_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_accept_ready got=%0h exp=0", req_ready); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_accept_valid got=%0h exp=1", rsp_valid); end
        @(posedge clk); #1;
`ifdef MULT_ARB_FIXED_PRIO_EN
        exp_next = 4'b0001;
`else
        exp_next = 4'b1000;
`endif
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got=%0h exp=0", rsp_valid); end
        checks++; if (req_ready !== exp_next) begin errors++; $display("FAIL bp_idle_grant got=%0h exp=%0h", req_ready, exp_next); end
        req_valid = 4'h0;
        rsp_ready = 1'b0;
    endtask

    // Reset asserted while requester 1 (3*5) is in BUSY.
    task automatic test_reset_mid();
        req_valid = 4'b0010;
        req_a     = 16'h0030;
        req_b     = 16'h0050;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant got=%0h exp=2", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'h0;
        rst_n     = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%0h exp=0", rsp_valid); end
        checks++; if (rsp_prod !== 8'h00) begin errors++; $display("FAIL rm_prod got=%0h exp=0", rsp_prod); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rm_id got=%0h exp=0", rsp_id); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_post_valid[%0d] got=%0h exp=0", c, rsp_valid); end
            checks++; if (rsp_prod !== 8'h00) begin errors++; $display("FAIL rm_post_prod[%0d] got=%0h exp=0", c, rsp_prod); end
            @(posedge clk); #1;
        end
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr_grant got=%0h exp=1", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'h0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rm_zero_valid got=%0h exp=1", rsp_valid); end
        checks++; if (rsp_prod !== 8'h00) begin errors++; $display("FAIL rm_zero_prod got=%0h exp=0", rsp_prod); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rm_zero_id got=%0h exp=0", rsp_id); end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // All 256 operand pairs through requester 3.
    task automatic test_exhaustive();
        logic [7:0] exp_p;
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                req_a = {4'(ia), 12'h000};
                req_b = {4'(ib), 12'h000};
                exp_p = 8'(ia * ib);
                #1;
                checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL ex_grant a=%0d b=%0d got=%0h exp=8", ia, ib, req_ready); end
                @(posedge clk); #1;
                @(posedge clk); #1;
                checks++; if (rsp_prod !== exp_p || rsp_valid !== 1'b1) begin errors++; $display("FAIL ex_prod a=%0d b=%0d got=%0h valid=%0h exp=%0h", ia, ib, rsp_prod, rsp_valid, exp_p); end
                checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL ex_id a=%0d b=%0d got=%0h exp=3", ia, ib, rsp_id); end
                @(posedge clk); #1;
            end
        end
        req_valid = 4'h0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
